// File: rtl/fe_pkg.sv
// Shared field constants and sequencer state encoding for the curve25519 datapath.
// All operands are 255-bit values in the multiplier's (possibly unreduced) representation.
package fe_pkg;

   localparam int FW = 255;

   // p = 2^255 - 19 and the inversion exponent p - 2, written as all-ones with a patched low byte
   localparam logic [FW-1:0] P         = {{(FW-8){1'b1}}, 8'hED};
   localparam logic [FW-1:0] P_MINUS_2 = {{(FW-8){1'b1}}, 8'hEB};
   localparam logic [FW-1:0] FE_ONE    = FW'(1);

   typedef enum logic [2:0] {
      ST_DRAIN,
      ST_IDLE,
      ST_SCAN,
      ST_SQ_WAIT,
      ST_MUL_WAIT,
      ST_FIN
   } pow_state_t;

endpackage

// File: rtl/fe_pow_ctrl_if.sv
// Request/result handshake plus the shared-multiplier port of the exponentiation sequencer.
// The slave side is the sequencer; the master side is the requester together with the multiplier.
interface fe_pow_ctrl_if #(
   parameter int EBITS = 255
);
   import fe_pkg::*;

   logic             start;
   logic [FW-1:0]    base_in;
   logic [EBITS-1:0] exp_in;
   logic             ready;
   logic             done;
   logic [FW-1:0]    out;
   logic             mul_start;
   logic [FW-1:0]    mul_a;
   logic [FW-1:0]    mul_b;
   logic             mul_done;
   logic [FW-1:0]    mul_out;

   modport slave (
      input  start, base_in, exp_in, mul_done, mul_out,
      output ready, done, out, mul_start, mul_a, mul_b
   );

   modport master (
      output start, base_in, exp_in, mul_done, mul_out,
      input  ready, done, out, mul_start, mul_a, mul_b
   );

endinterface

// File: rtl/fe_pow_ctrl.sv
// Left-to-right square-and-multiply sequencer computing base^exp mod p over one external
// field multiplier; one operation in flight, all outputs registered.
module fe_pow_ctrl
   import fe_pkg::*;
#(
   parameter int EBITS = 255,
   parameter int DRAIN = 40,
   parameter int CW    = 8
) (
   input  logic          clock,
   input  logic          reset,
   fe_pow_ctrl_if.slave  bus
);

   localparam int DW = $clog2(DRAIN + 1);

   pow_state_t       state;
   logic [DW-1:0]    drain_cnt;
   logic [CW-1:0]    idx;
   logic             seen;
   logic [FW-1:0]    acc;
   logic [FW-1:0]    base_r;
   logic [EBITS-1:0] exp_r;

   logic             ready_r;
   logic             done_r;
   logic [FW-1:0]    out_r;
   logic             mul_start_r;
   logic [FW-1:0]    mul_a_r;
   logic [FW-1:0]    mul_b_r;

   assign bus.ready     = ready_r;
   assign bus.done      = done_r;
   assign bus.out       = out_r;
   assign bus.mul_start = mul_start_r;
   assign bus.mul_a     = mul_a_r;
   assign bus.mul_b     = mul_b_r;

   // Whole sequencer in one clocked block. Entering FIN raises done and loads out in the
   // same edge, so done and the result appear together and ready returns one cycle later.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_DRAIN;
         drain_cnt   <= DW'(DRAIN);
         idx         <= '0;
         seen        <= 1'b0;
         acc         <= FE_ONE;
         base_r      <= '0;
         exp_r       <= '0;
         ready_r     <= 1'b0;
         done_r      <= 1'b0;
         out_r       <= FE_ONE;
         mul_start_r <= 1'b0;
         mul_a_r     <= '0;
         mul_b_r     <= '0;
      end else begin
         done_r      <= 1'b0;
         mul_start_r <= 1'b0;
         case (state)
            // Waits out any multiply that was still running when reset hit
            ST_DRAIN: begin
               if (drain_cnt == '0) begin
                  state   <= ST_IDLE;
                  ready_r <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt - 1'b1;
               end
            end
            ST_IDLE: begin
               if (bus.start) begin
                  base_r  <= bus.base_in;
                  exp_r   <= bus.exp_in;
                  idx     <= CW'(EBITS - 1);
                  seen    <= 1'b0;
                  acc     <= FE_ONE;
                  ready_r <= 1'b0;
                  state   <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (!seen) begin
                  if (exp_r[idx]) begin
                     acc  <= base_r;
                     seen <= 1'b1;
                  end
                  if (idx == '0) begin
                     out_r  <= exp_r[idx] ? base_r : acc;
                     done_r <= 1'b1;
                     state  <= ST_FIN;
                  end else begin
                     idx <= idx - 1'b1;
                  end
               end else begin
                  mul_start_r <= 1'b1;
                  mul_a_r     <= acc;
                  mul_b_r     <= acc;
                  state       <= ST_SQ_WAIT;
               end
            end
            ST_SQ_WAIT: begin
               if (bus.mul_done) begin
                  acc <= bus.mul_out;
                  if (exp_r[idx]) begin
                     mul_start_r <= 1'b1;
                     mul_a_r     <= bus.mul_out;
                     mul_b_r     <= base_r;
                     state       <= ST_MUL_WAIT;
                  end else if (idx == '0) begin
                     out_r  <= bus.mul_out;
                     done_r <= 1'b1;
                     state  <= ST_FIN;
                  end else begin
                     idx   <= idx - 1'b1;
                     state <= ST_SCAN;
                  end
               end
            end
            ST_MUL_WAIT: begin
               if (bus.mul_done) begin
                  acc <= bus.mul_out;
                  if (idx == '0) begin
                     out_r  <= bus.mul_out;
                     done_r <= 1'b1;
                     state  <= ST_FIN;
                  end else begin
                     idx   <= idx - 1'b1;
                     state <= ST_SCAN;
                  end
               end
            end
            ST_FIN: begin
               ready_r <= 1'b1;
               state   <= ST_IDLE;
            end
            default: begin
               state     <= ST_DRAIN;
               drain_cnt <= DW'(DRAIN);
               ready_r   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fe_pow_ctrl.sv
// Directed bench for fe_pow_ctrl with a behavioural modular multiplier of fixed latency.
// Expected results are small hand-worked powers plus the known inverse of 2 mod p.
module tb_fe_pow_ctrl;
   import fe_pkg::*;

   localparam int EBITS   = 255;
   localparam int DRAIN   = 40;
   localparam int CW      = 8;
   localparam int MUL_LAT = 4;
   localparam int BUDGET  = 20000;

   logic clock = 1'b0;
   logic reset = 1'b1;

   fe_pow_ctrl_if #(.EBITS(EBITS)) bus();

   fe_pow_ctrl #(.EBITS(EBITS), .DRAIN(DRAIN), .CW(CW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   int mul_pulses  = 0;
   int overlap     = 0;
   int done_pulses = 0;

   logic          mbusy = 1'b0;
   int            mcnt  = 0;
   logic [FW-1:0] ma, mb;

   function automatic logic [FW-1:0] fmul(input logic [FW-1:0] a, input logic [FW-1:0] b);
      logic [2*FW-1:0] prod;
      logic [2*FW-1:0] modv;
      prod = {{FW{1'b0}}, a} * {{FW{1'b0}}, b};
      modv = prod % {{FW{1'b0}}, P};
      return modv[FW-1:0];
   endfunction

   // Multiplier model is deliberately not reset, so a multiply cut off by reset still completes
   always @(posedge clock) begin
      bus.mul_done <= 1'b0;
      if (mbusy) begin
         if (mcnt == 0) begin
            bus.mul_done <= 1'b1;
            bus.mul_out  <= fmul(ma, mb);
            mbusy        <= 1'b0;
         end else begin
            mcnt <= mcnt - 1;
         end
      end
      if (bus.mul_start === 1'b1) begin
         if (mbusy) overlap++;
         mul_pulses++;
         mbusy <= 1'b1;
         mcnt  <= MUL_LAT;
         ma    <= bus.mul_a;
         mb    <= bus.mul_b;
      end
      if (bus.done === 1'b1) done_pulses++;
   end

   task automatic check_output(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Issues one request, optionally pokes a second start during the first square wait,
   // and returns the result plus cycles from acceptance to done and the multiply count.
   task automatic apply_stimulus(input logic [FW-1:0] b, input logic [EBITS-1:0] e, input bit poke,
                                 output logic [FW-1:0] res, output int cyc, output int pulses,
                                 output bit tmo);
      int  p0;
      int  wait_cyc;
      bit  poked;
      tmo      = 1'b0;
      poked    = 1'b0;
      wait_cyc = 0;
      while (bus.ready !== 1'b1 && wait_cyc < BUDGET) begin
         @(negedge clock);
         wait_cyc++;
      end
      if (wait_cyc >= BUDGET) tmo = 1'b1;
      p0          = mul_pulses;
      bus.start   = 1'b1;
      bus.base_in = b;
      bus.exp_in  = e;
      @(negedge clock);
      bus.start = 1'b0;
      cyc = 1;
      while (bus.done !== 1'b1 && cyc < BUDGET) begin
         if (poke && !poked && bus.mul_start === 1'b1) begin
            bus.start   = 1'b1;
            bus.base_in = FW'(9);
            bus.exp_in  = EBITS'(7);
            poked       = 1'b1;
         end
         @(negedge clock);
         bus.start = 1'b0;
         cyc++;
      end
      if (cyc >= BUDGET) tmo = 1'b1;
      res    = bus.out;
      pulses = mul_pulses - p0;
   endtask

   // Checks the result, the multiply count, a single done pulse, and ready returning next cycle
   task automatic check_op(input string tag, input logic [FW-1:0] b, input logic [EBITS-1:0] e,
                           input bit poke, input logic [FW-1:0] want, input int want_pulses,
                           input int want_cyc);
      logic [FW-1:0] res;
      int            cyc, pulses, d0;
      bit            tmo;
      d0 = done_pulses;
      apply_stimulus(b, e, poke, res, cyc, pulses, tmo);
      check_output({tag, "_timeout"}, FW'(tmo), FW'(0));
      check_output({tag, "_out"}, res, want);
      check_output({tag, "_mul_pulses"}, FW'(pulses), FW'(want_pulses));
      check_output({tag, "_ready_at_done"}, FW'(bus.ready), FW'(0));
      if (want_cyc > 0) check_output({tag, "_latency"}, FW'(cyc), FW'(want_cyc));
      @(negedge clock);
      check_output({tag, "_done_low"}, FW'(bus.done), FW'(0));
      check_output({tag, "_ready_after"}, FW'(bus.ready), FW'(1));
      check_output({tag, "_done_count"}, FW'(done_pulses - d0), FW'(1));
      check_output({tag, "_out_held"}, bus.out, want);
   endtask

   initial begin
      int            n;
      int            p0, d0;
      bit            saw_done, tmo;
      logic [FW-1:0] inv2;

      bus.start   = 1'b0;
      bus.base_in = '0;
      bus.exp_in  = '0;
      reset       = 1'b1;
      repeat (2) @(negedge clock);
      check_output("rst_ready", FW'(bus.ready), FW'(0));
      check_output("rst_done", FW'(bus.done), FW'(0));
      check_output("rst_out", bus.out, FW'(1));
      check_output("rst_mul_start", FW'(bus.mul_start), FW'(0));
      check_output("rst_mul_a", bus.mul_a, FW'(0));
      check_output("rst_mul_b", bus.mul_b, FW'(0));

      reset = 1'b0;
      n = 0;
      while (bus.ready !== 1'b1 && n < BUDGET) begin
         @(negedge clock);
         n++;
      end
      check_output("drain_len", FW'(n), FW'(DRAIN + 1));

      check_op("pow3_5", FW'(3), EBITS'(5), 1'b0, FW'(243), 3, 0);
      check_op("exp0", FW'(7), EBITS'(0), 1'b0, FW'(1), 0, EBITS + 1);
      check_op("exp1", FW'(16'h1234), EBITS'(1), 1'b0, FW'(16'h1234), 0, EBITS + 1);

      inv2 = {1'b0, {246{1'b1}}, 8'hF7};
      check_op("inv2", FW'(2), P_MINUS_2, 1'b0, inv2, 506, 0);
      check_output("inv2_times2", fmul(inv2, FW'(2)), FW'(1));

      check_op("poke", FW'(3), EBITS'(5), 1'b1, FW'(243), 3, 0);

      // Abort: reset lands three cycles after the first square request
      n = 0;
      while (bus.ready !== 1'b1 && n < BUDGET) begin
         @(negedge clock);
         n++;
      end
      bus.start   = 1'b1;
      bus.base_in = FW'(3);
      bus.exp_in  = EBITS'(5);
      @(negedge clock);
      bus.start = 1'b0;
      n = 0;
      while (bus.mul_start !== 1'b1 && n < BUDGET) begin
         @(negedge clock);
         n++;
      end
      tmo = (n >= BUDGET);
      check_output("abort_timeout", FW'(tmo), FW'(0));
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset    = 1'b0;
      d0       = done_pulses;
      p0       = mul_pulses;
      saw_done = 1'b0;
      n        = 0;
      while (bus.ready !== 1'b1 && n < BUDGET) begin
         @(negedge clock);
         n++;
         if (bus.done === 1'b1) saw_done = 1'b1;
      end
      check_output("abort_drain_len", FW'(n), FW'(DRAIN + 1));
      check_output("abort_no_done", FW'(saw_done), FW'(0));
      check_output("abort_done_count", FW'(done_pulses - d0), FW'(0));
      check_output("abort_no_mul", FW'(mul_pulses - p0), FW'(0));
      check_output("abort_out_reset", bus.out, FW'(1));

      check_op("after_abort", FW'(3), EBITS'(5), 1'b0, FW'(243), 3, 0);

      check_output("mul_overlap", FW'(overlap), FW'(0));

      $display("[TB] directed sequence complete");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fe_pow_ctrl.md
Name: fe_pow_ctrl

Overview:
Sequencer that computes base^exp mod p (p = 2^255-19) by left-to-right square-and-multiply over one shared field multiplier. The multiplier is instantiated beside this block and driven through the mul_* ports. Primary use is field inversion (exp = p-2) and other fixed-exponent chains in the curve25519 datapath. One operation in flight at a time.

Parameters:
EBITS, 255, exponent width in bits; scan runs from bit EBITS-1 down to bit 0.
DRAIN, 40, post-reset cycles the block waits before accepting start; must exceed multiplier start-to-done latency.
CW, 8, bit-index counter width; must satisfy 2^CW > EBITS.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request; sampled only when ready=1
base_in  in  255  base operand, latched on accepted start
exp_in  in  EBITS  exponent, latched on accepted start
ready  out  1  high in IDLE only
done  out  1  one-cycle pulse; out valid from this cycle
out  out  255  result, congruent to base^exp mod p; held until next accepted start
mul_start  out  1  one-cycle pulse to the multiplier
mul_a  out  255  multiplier operand A; stable from mul_start until mul_done
mul_b  out  255  multiplier operand B; same stability rule
mul_done  in  1  multiplier completion pulse
mul_out  in  255  multiplier result, valid with mul_done

Behaviour:
- Clock is clock. Reset is synchronous and active-high. On reset: state=DRAIN, drain counter=DRAIN, ready=0, done=0, mul_start=0, out=1, mul_a=mul_b=0.
- States:
  - DRAIN: decrement each cycle and ignore mul_done. At 0, go to IDLE. This absorbs a stray mul_done from a multiply that was in flight when reset hit.
  - IDLE: ready=1. start latches base and exp, sets i=EBITS-1, seen=0, acc=1, and goes to SCAN.
  - SCAN, one cycle per step, on bit i:
    - seen=0: if exp[i]=1, acc=base and seen=1 (no multiply). Then, if i=0, go to FIN; else i=i-1.
    - seen=1: pulse mul_start with mul_a=mul_b=acc, go to SQ_WAIT.
  - SQ_WAIT: on mul_done, acc=mul_out.
    - If exp[i]=1: pulse mul_start with mul_a=mul_out and mul_b=base, go to MUL_WAIT.
    - Else: go to FIN if i=0; otherwise i=i-1 and return to SCAN.
  - MUL_WAIT: on mul_done, acc=mul_out. Go to FIN if i=0; otherwise i=i-1 and return to SCAN.
  - FIN: out=acc, done=1 for exactly one cycle, then IDLE.
- Costs:
  - Leading zeros cost one cycle each and no multiplies.
  - The first set bit costs one cycle and no multiply.
  - Every subsequent bit costs one square, plus one multiply if the bit is set.
- exp=0: out=1 after EBITS SCAN cycles, with zero mul_start pulses.
- start while ready=0 is ignored; latched operands are not disturbed.
- mul_done outside SQ_WAIT or MUL_WAIT is ignored.
- mul_start never pulses while a multiply is outstanding.
- No reduction is applied: out is the multiplier's representation, below 2^255 but possibly ≥ p. base=1 or exp=1 passes base through unchanged.
- Reset mid-operation aborts immediately, drops the result (no done), and enters DRAIN.

Decomposition:
- Shared package fe_pkg:
  - field width 255
  - P constant
  - P_MINUS_2 exponent constant
  - state enum encoding
- No sub-module. The multiplier stays external so a later arbiter can share it.

Test Plan:
- base=3, exp=5 -> out=243. Exactly 3 mul_start pulses (2 squares, 1 multiply). done once. ready returns the cycle after done.
- exp=0, base=7 -> out=1. Zero mul_start pulses. done exactly EBITS+1 cycles after the cycle start was accepted.
- exp=1, base=0x1234 -> out=0x1234. Zero mul_start pulses.
- base=2, exp=p-2 -> (out*2) mod p = 1, i.e. out ≡ 2^254-9 mod p. Exactly 506 mul_start pulses (254 squares + 252 multiplies).
- Second start pulsed during SQ_WAIT of a base=3, exp=5 run -> ignored. Result is still 243 and operands are unchanged.
- Reset asserted 3 cycles after a mul_start -> done never pulses. ready stays 0 for DRAIN cycles and the stray mul_done is ignored. A following base=3, exp=5 run returns 243.
